frenzy_input_ctrl: RTL and testbench

FRENZY_INPUT_CTRL -- requirements
Module: frenzy_input_ctrl

---
 rtl/frenzy_input_ctrl.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_frenzy_input_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frenzy_input_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// frenzy_input_ctrl
//
// Merges PS/2 keyboard events and two joystick pads into the player controls
// of the game core. It also shapes any coin request into one fixed-length coin
// pulse, followed by a holdoff period.
//
// Ports
//   clk_sys         in   system clock; all state changes on the rising edge
//   reset_n         in   asynchronous active-low reset
//   ps2_key[10:0]   in   [10] toggles once per key event, [9] pressed,
//                        [8] extended prefix, [7:0] scancode
//   joystick_0/1    in   pads: [0] R [1] L [2] D [3] U [4] fire
//                        [5] start1 [6] start2 [7] coin; [15:8] unused
//   rotate          in   1 = turn directions 90 degrees for a vertical monitor
//   up1..fire1      out  player 1 controls, registered, active-high
//   up2..fire2      out  player 2 controls, registered, active-high
//   start1, start2  out  start buttons (level), registered
//   coin1           out  shaped coin pulse, COIN_LEN cycles long
//   coin_state_dbg  out  current coin FSM state (coin_state_e encoding)
//
// Handshake: none. Every input is a level. A key event is a change of
// ps2_key[10] against its registered copy, and the decoder takes each
// event exactly once.
// -----------------------------------------------------------------------------
module frenzy_input_ctrl #(
  parameter int COIN_LEN = 400000,
  parameter int COIN_GAP = 2000000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  input  logic        rotate,
  output logic        up1,
  output logic        down1,
  output logic        left1,
  output logic        right1,
  output logic        fire1,
  output logic        up2,
  output logic        down2,
  output logic        left2,
  output logic        right2,
  output logic        fire2,
  output logic        start1,
  output logic        start2,
  output logic        coin1,
  output logic [1:0]  coin_state_dbg
);

  typedef enum logic [1:0] {
    C_IDLE     = 2'd0,
    C_PULSE    = 2'd1,
    C_HOLD     = 2'd2,
    C_WAIT_REL = 2'd3
  } coin_state_e;

  // One latch per physical key. A function that several keys share is the
  // OR of its keys, so releasing one key leaves any other held key in effect.
  localparam int K_UP1   = 0;
  localparam int K_DN1   = 1;
  localparam int K_LF1   = 2;
  localparam int K_RT1   = 3;
  localparam int K_SPACE = 4;
  localparam int K_CTRL  = 5;
  localparam int K_F1    = 6;
  localparam int K_ONE   = 7;
  localparam int K_F2    = 8;
  localparam int K_TWO   = 9;
  localparam int K_FIVE  = 10;
  localparam int K_SIX   = 11;
  localparam int K_UP2   = 12;
  localparam int K_DN2   = 13;
  localparam int K_LF2   = 14;
  localparam int K_RT2   = 15;
  localparam int K_FIRE2 = 16;
  localparam int NKEYS   = 17;

  localparam logic [21:0] LEN_LOAD = 22'(COIN_LEN - 1);
  localparam logic [21:0] GAP_LOAD = 22'(COIN_GAP - 1);

  // ---------------------------------------------------------------------------
  // Key event detection
  // ---------------------------------------------------------------------------
  logic tog_q;
  logic prime_q;
  logic key_evt;

  // During the first cycle after reset the toggle copy only tracks the input.
  // A toggle level held across reset is therefore never taken as an event.
  assign key_evt = !prime_q && (ps2_key[10] != tog_q);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      tog_q   <= 1'b0;
      prime_q <= 1'b1;
    end else begin
      tog_q   <= ps2_key[10];
      prime_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Key decode into per-key latches
  // ---------------------------------------------------------------------------
  logic [NKEYS-1:0] keys_q;
  logic [NKEYS-1:0] keys_d;

  always_comb begin
    keys_d = keys_q;
    if (key_evt) begin
      case ({ps2_key[8], ps2_key[7:0]})
        // Arrow keys match with or without the extended prefix.
        9'h075, 9'h175: keys_d[K_UP1]   = ps2_key[9];
        9'h072, 9'h172: keys_d[K_DN1]   = ps2_key[9];
        9'h06B, 9'h16B: keys_d[K_LF1]   = ps2_key[9];
        9'h074, 9'h174: keys_d[K_RT1]   = ps2_key[9];
        9'h029:         keys_d[K_SPACE] = ps2_key[9];
        9'h014:         keys_d[K_CTRL]  = ps2_key[9];
        9'h005:         keys_d[K_F1]    = ps2_key[9];
        9'h016:         keys_d[K_ONE]   = ps2_key[9];
        9'h006:         keys_d[K_F2]    = ps2_key[9];
        9'h01E:         keys_d[K_TWO]   = ps2_key[9];
        9'h02E:         keys_d[K_FIVE]  = ps2_key[9];
        9'h036:         keys_d[K_SIX]   = ps2_key[9];
        9'h02D:         keys_d[K_UP2]   = ps2_key[9];
        9'h02B:         keys_d[K_DN2]   = ps2_key[9];
        9'h023:         keys_d[K_LF2]   = ps2_key[9];
        9'h034:         keys_d[K_RT2]   = ps2_key[9];
        9'h01C:         keys_d[K_FIRE2] = ps2_key[9];
        default: ;
      endcase
    end
  end

  // The joystick and rotate inputs pass through one register here. That
  // gives them the same two-edge latency as the keyboard path: latch, then
  // output register.
  logic [6:0] joy0_q;
  logic [6:0] joy1_q;
  logic       rot_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      keys_q <= '0;
      joy0_q <= '0;
      joy1_q <= '0;
      rot_q  <= 1'b0;
    end else begin
      keys_q <= keys_d;
      joy0_q <= joystick_0[6:0];
      joy1_q <= joystick_1[6:0];
      rot_q  <= rotate;
    end
  end

  // The upper pad bits carry nothing for this core.
  logic unused_joy_hi;
  assign unused_joy_hi = ^{joystick_0[15:8], joystick_1[15:8]};

  // ---------------------------------------------------------------------------
  // Direction merge, rotation and output registers
  // ---------------------------------------------------------------------------
  // Direction vectors are ordered {up, down, left, right}.
  function automatic logic [3:0] orient(input logic [3:0] raw, input logic rot);
    // On a rotated monitor: up <- left, down <- right, left <- down, right <- up.
    orient = rot ? {raw[1], raw[0], raw[2], raw[3]} : raw;
  endfunction

  logic [3:0] raw1;
  logic [3:0] raw2;
  logic [3:0] dir1_d, dir1_q;
  logic [3:0] dir2_d, dir2_q;
  logic       fire1_d, fire1_q;
  logic       fire2_d, fire2_q;
  logic       start1_d, start1_q;
  logic       start2_d, start2_q;

  always_comb begin
    raw1 = {keys_q[K_UP1] | joy0_q[3], keys_q[K_DN1] | joy0_q[2],
            keys_q[K_LF1] | joy0_q[1], keys_q[K_RT1] | joy0_q[0]};
    raw2 = {keys_q[K_UP2] | joy1_q[3], keys_q[K_DN2] | joy1_q[2],
            keys_q[K_LF2] | joy1_q[1], keys_q[K_RT2] | joy1_q[0]};
    dir1_d   = orient(raw1, rot_q);
    dir2_d   = orient(raw2, rot_q);
    fire1_d  = keys_q[K_SPACE] | keys_q[K_CTRL] | joy0_q[4];
    fire2_d  = keys_q[K_FIRE2] | joy1_q[4];
    // Either pad may start either player.
    start1_d = keys_q[K_F1] | keys_q[K_ONE] | joy0_q[5] | joy1_q[5];
    start2_d = keys_q[K_F2] | keys_q[K_TWO] | joy0_q[6] | joy1_q[6];
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dir1_q   <= '0;
      dir2_q   <= '0;
      fire1_q  <= 1'b0;
      fire2_q  <= 1'b0;
      start1_q <= 1'b0;
      start2_q <= 1'b0;
    end else begin
      dir1_q   <= dir1_d;
      dir2_q   <= dir2_d;
      fire1_q  <= fire1_d;
      fire2_q  <= fire2_d;
      start1_q <= start1_d;
      start2_q <= start2_d;
    end
  end

  assign {up1, down1, left1, right1} = dir1_q;
  assign {up2, down2, left2, right2} = dir2_q;
  assign fire1  = fire1_q;
  assign fire2  = fire2_q;
  assign start1 = start1_q;
  assign start2 = start2_q;

  // ---------------------------------------------------------------------------
  // Coin request shaping
  // ---------------------------------------------------------------------------
  logic        coin_req;
  logic        coin_req_q;
  logic        coin_req_p_q;
  logic        coin_rise;
  coin_state_e state_q, state_d;
  logic [21:0] cnt_q, cnt_d;
  logic        coin1_q;

  assign coin_req  = keys_q[K_FIVE] | keys_q[K_SIX] | joystick_0[7] | joystick_1[7];
  assign coin_rise = coin_req_q & ~coin_req_p_q;

  // A rising edge counts only in IDLE. Edges that arrive in any other state
  // are dropped, so a coin held down gives exactly one pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      C_IDLE: begin
        if (coin_rise) begin
          state_d = C_PULSE;
          cnt_d   = LEN_LOAD;
        end
      end
      C_PULSE: begin
        if (cnt_q == '0) begin
          state_d = C_HOLD;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - 22'd1;
        end
      end
      C_HOLD: begin
        if (cnt_q == '0) begin
          state_d = coin_req_q ? C_WAIT_REL : C_IDLE;
        end else begin
          cnt_d = cnt_q - 22'd1;
        end
      end
      C_WAIT_REL: begin
        if (!coin_req_q) begin
          state_d = C_IDLE;
        end
      end
      default: begin
        state_d = C_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      coin_req_q   <= 1'b0;
      coin_req_p_q <= 1'b0;
      state_q      <= C_IDLE;
      cnt_q        <= '0;
      coin1_q      <= 1'b0;
    end else begin
      coin_req_q   <= coin_req;
      coin_req_p_q <= coin_req_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      coin1_q      <= (state_d == C_PULSE);
    end
  end

  assign coin1          = coin1_q;
  assign coin_state_dbg = state_q;

endmodule

// File: tb/tb_frenzy_input_ctrl.sv
`timescale 1ns/1ps
module tb_frenzy_input_ctrl;

  localparam int LEN = 4;
  localparam int GAP = 8;

  // ---------------------------------------------------------------- clock/reset
  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] ps2_key = '0;
  logic [15:0] joystick_0 = '0;
  logic [15:0] joystick_1 = '0;
  logic        rotate = 1'b0;
  logic up1, down1, left1, right1, fire1;
  logic up2, down2, left2, right2, fire2;
  logic start1, start2, coin1;
  logic [1:0] coin_state_dbg;

  always #5 clk_sys = ~clk_sys;

  frenzy_input_ctrl #(.COIN_LEN(LEN), .COIN_GAP(GAP)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key),
    .joystick_0(joystick_0), .joystick_1(joystick_1), .rotate(rotate),
    .up1(up1), .down1(down1), .left1(left1), .right1(right1), .fire1(fire1),
    .up2(up2), .down2(down2), .left2(left2), .right2(right2), .fire2(fire2),
    .start1(start1), .start2(start2), .coin1(coin1),
    .coin_state_dbg(coin_state_dbg)
  );

  // ---------------------------------------------------------------- scoreboard
  logic [12:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;
  int hi_cycles = 0;
  logic coin_prev = 1'b0;
  logic [12:0] got_v, want_v;

  // Output vector: {up1,down1,left1,right1,fire1,up2,down2,left2,right2,fire2,start1,start2,coin1}
  always @(negedge clk_sys) begin
    if (exp_q.size() != 0) begin
      got_v  = {up1, down1, left1, right1, fire1, up2, down2, left2, right2, fire2,
                start1, start2, coin1};
      want_v = exp_q.pop_front();
      n_cmp++;
      if (got_v !== want_v) begin
        n_bad++;
        $display("FAIL outputs t=%0t got=%b want=%b", $time, got_v, want_v);
      end
    end
    if (coin1 === 1'b1 && coin_prev !== 1'b1) pulses++;
    if (coin1 === 1'b1) hi_cycles++;
    coin_prev = coin1;
  end

  task automatic check_eq(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // ---------------------------------------------------------------- reference model
  // Key table: the first four entries are arrows and match with either prefix.
  // Slot numbers are positions in this table.
  logic [7:0] key_code [17] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h14, 8'h05, 8'h16,
                                8'h06, 8'h1E, 8'h2E, 8'h36, 8'h2D, 8'h2B, 8'h23, 8'h34,
                                8'h1C};
  logic [7:0] junk_code [3] = '{8'h12, 8'h5A, 8'h66};

  function automatic int slot_of(input logic ext, input logic [7:0] code);
    slot_of = -1;
    for (int i = 0; i < 17; i++)
      if (code == key_code[i] && (i < 4 || !ext)) slot_of = i;
  endfunction

  function automatic logic [3:0] turn(input logic [3:0] udlr, input logic rot);
    // A rotated monitor shows the raw left as up, right as down, down as left and up as right.
    turn = rot ? {udlr[1], udlr[0], udlr[2], udlr[3]} : udlr;
  endfunction

  function automatic logic [11:0] controls(input logic [16:0] h, input logic [15:0] j0,
                                           input logic [15:0] j1, input logic rot);
    logic [3:0] p1, p2;
    p1 = turn({h[0] | j0[3], h[1] | j0[2], h[2] | j0[1], h[3] | j0[0]}, rot);
    p2 = turn({h[12] | j1[3], h[13] | j1[2], h[14] | j1[1], h[15] | j1[0]}, rot);
    controls = {p1, h[4] | h[5] | j0[4], p2, h[16] | j1[4],
                h[6] | h[7] | j0[5] | j1[5], h[8] | h[9] | j0[6] | j1[6]};
  endfunction

  // Staged inputs (next) and the values currently on the DUT pins (cur).
  logic        nx_rst = 1'b0, cur_rst = 1'b0;
  logic [10:0] nx_ps2 = '0;
  logic [15:0] nx_j0 = '0, cur_j0 = '0, nx_j1 = '0, cur_j1 = '0;
  logic        nx_rot = 1'b0, cur_rot = 1'b0;
  logic        nx_evt = 1'b0, cur_evt = 1'b0;
  int          nx_slot = -1, cur_slot = -1;
  logic        nx_pr = 1'b0, cur_pr = 1'b0;

  // Model state: the key set seen by the game, short input history, coin timing.
  logic [16:0] m_held = '0;
  logic [16:0] h_held [8];
  logic [15:0] h_j0 [8];
  logic [15:0] h_j1 [8];
  logic        h_rot [8];
  logic        h_creq [8];
  int          ecnt = 0;
  logic        after_rst = 1'b1;
  logic        c_idle = 1'b1;
  logic        c_wait = 1'b0;
  int          c_start = 0;

  initial begin
    for (int i = 0; i < 8; i++) begin
      h_held[i] = '0; h_j0[i] = '0; h_j1[i] = '0; h_rot[i] = 1'b0; h_creq[i] = 1'b0;
    end
  end

  // Advance one clock edge. Then drive the staged inputs and push the outputs
  // expected until the next edge.
  task automatic tick();
    logic [12:0] e_v;
    int i0, i1, i2;
    logic rise;
    @(posedge clk_sys);
    ecnt++;
    i0 = ecnt & 7; i1 = (ecnt - 1) & 7; i2 = (ecnt - 2) & 7;
    if (!cur_rst) begin
      m_held = '0;
      h_held[i0] = '0; h_j0[i0] = '0; h_j1[i0] = '0; h_rot[i0] = 1'b0; h_creq[i0] = 1'b0;
      c_idle = 1'b1; c_wait = 1'b0; after_rst = 1'b1;
      e_v = '0;
    end else begin
      // A key event is ignored on the first edge after reset.
      if (cur_evt && !after_rst && cur_slot >= 0) m_held[cur_slot] = cur_pr;
      after_rst = 1'b0;
      h_held[i0] = m_held; h_j0[i0] = cur_j0; h_j1[i0] = cur_j1; h_rot[i0] = cur_rot;
      h_creq[i0] = h_held[i1][10] | h_held[i1][11] | cur_j0[7] | cur_j1[7];
      rise = h_creq[i1] && !h_creq[i2];
      if (c_idle) begin
        if (rise) begin c_idle = 1'b0; c_start = ecnt; end
      end else if (c_wait) begin
        if (!h_creq[i1]) begin c_wait = 1'b0; c_idle = 1'b1; end
      end else if (ecnt == c_start + LEN + GAP) begin
        if (h_creq[i1]) c_wait = 1'b1; else c_idle = 1'b1;
      end
      e_v = {controls(h_held[i1], h_j0[i1], h_j1[i1], h_rot[i1]),
             (!c_idle && !c_wait && (ecnt - c_start) < LEN)};
    end
    #1;
    cur_rst = nx_rst; cur_j0 = nx_j0; cur_j1 = nx_j1; cur_rot = nx_rot;
    cur_evt = nx_evt; cur_slot = nx_slot; cur_pr = nx_pr;
    nx_evt = 1'b0;
    reset_n = cur_rst; ps2_key = nx_ps2; joystick_0 = cur_j0; joystick_1 = cur_j1; rotate = cur_rot;
    if (!cur_rst) begin
      // The reset is asynchronous, so every output is already low in this interval.
      m_held = '0; c_idle = 1'b1; c_wait = 1'b0; e_v = '0;
    end
    exp_q.push_back(e_v);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------------------------------------------------------- driver tasks
  task automatic send_key(input logic pressed, input logic ext, input logic [7:0] code);
    nx_ps2  = {~nx_ps2[10], pressed, ext, code};
    nx_evt  = 1'b1;
    nx_slot = slot_of(ext, code);
    nx_pr   = pressed;
    tick();
  endtask

  // ---------------------------------------------------------------- stimulus
  int p0, hc0;
  int r;
  initial begin
    ticks(4);
    nx_rst = 1'b1;
    ticks(4);

    // Arrow with the extended prefix: up1 follows two edges after the event.
    send_key(1'b1, 1'b1, 8'h75);
    tick();
    check_eq("up1_one_edge", int'(up1), 0);
    tick();
    check_eq("up1_two_edges", int'(up1), 1);
    send_key(1'b0, 1'b1, 8'h75);
    ticks(2);
    check_eq("up1_release", int'(up1), 0);

    // Rotation: pad right becomes down, pad up on player 2 becomes right.
    nx_rot = 1'b1; nx_j0 = 16'h0001;
    ticks(3);
    check_eq("rot_up1", int'(up1), 0);
    check_eq("rot_down1", int'(down1), 1);
    check_eq("rot_right1", int'(right1), 0);
    nx_j1 = 16'h0008;
    ticks(3);
    check_eq("rot_right2", int'(right2), 1);
    nx_rot = 1'b0; nx_j0 = '0; nx_j1 = '0;
    ticks(3);

    // Two keys share fire1.
    send_key(1'b1, 1'b0, 8'h29);
    send_key(1'b1, 1'b0, 8'h14);
    ticks(3);
    send_key(1'b0, 1'b0, 8'h14);
    ticks(3);
    check_eq("fire1_space_held", int'(fire1), 1);
    send_key(1'b0, 1'b0, 8'h29);
    ticks(3);
    check_eq("fire1_all_released", int'(fire1), 0);

    // Holding '5' yields one pulse of LEN cycles.
    p0 = pulses; hc0 = hi_cycles;
    send_key(1'b1, 1'b0, 8'h2E);
    ticks(100);
    check_eq("hold_pulse_count", pulses - p0, 1);
    check_eq("hold_pulse_width", hi_cycles - hc0, LEN);
    send_key(1'b0, 1'b0, 8'h2E);
    ticks(5);
    p0 = pulses; hc0 = hi_cycles;
    send_key(1'b1, 1'b0, 8'h2E);
    ticks(20);
    check_eq("second_pulse_count", pulses - p0, 1);
    check_eq("second_pulse_width", hi_cycles - hc0, LEN);
    send_key(1'b0, 1'b0, 8'h2E);
    ticks(20);

    // A re-press during the holdoff is dropped. Release and press again gives a new pulse.
    p0 = pulses; hc0 = hi_cycles;
    send_key(1'b1, 1'b0, 8'h2E);
    tick();
    send_key(1'b0, 1'b0, 8'h2E);
    ticks(4);
    send_key(1'b1, 1'b0, 8'h2E);
    ticks(20);
    check_eq("repress_in_hold", pulses - p0, 1);
    send_key(1'b0, 1'b0, 8'h2E);
    ticks(3);
    send_key(1'b1, 1'b0, 8'h2E);
    ticks(15);
    check_eq("press_after_release", pulses - p0, 2);
    check_eq("press_after_release_width", hi_cycles - hc0, 2 * LEN);
    send_key(1'b0, 1'b0, 8'h2E);
    ticks(20);

    // Reset during the second pulse cycle, with the toggle held high across reset.
    send_key(1'b1, 1'b0, 8'h2E);
    ticks(3);
    nx_rst = 1'b0;
    nx_ps2 = 11'b1_1_0_0010_1110;
    tick();
    #1;
    check_eq("coin1_async_drop", int'(coin1), 0);
    ticks(3);
    p0 = pulses;
    nx_rst = 1'b1;
    ticks(30);
    check_eq("no_pulse_after_reset", pulses - p0, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 2500; n++) begin
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 399) == 0) begin
        nx_rst = 1'b0;
        ticks(2);
        nx_rst = 1'b1;
        tick();
      end else if (r < 14) begin
        int k;
        logic [7:0] c;
        k = $urandom_range(0, 19);
        c = (k < 17) ? key_code[k] : junk_code[k - 17];
        send_key(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), c);
      end else if (r < 18) begin
        nx_j0 = 16'($urandom);
        nx_j1 = 16'($urandom);
        if ($urandom_range(0, 3) != 0) nx_j0[7] = 1'b0;
        if ($urandom_range(0, 3) != 0) nx_j1[7] = 1'b0;
        tick();
      end else if (r < 20) begin
        nx_rot = ~nx_rot;
        tick();
      end else begin
        tick();
      end
    end

    nx_j0 = '0; nx_j1 = '0; nx_rot = 1'b0;
    ticks(20);
    @(negedge clk_sys);
    #1;
    check_eq("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
